// File: rtl/mode7_frame_ctrl.sv
// Mode 7 frame sequencer: keeps shadow/active transform parameters, commits
// them at frame start (with optional auto-rotation), sweeps pixel coordinates
// into the affine datapath and streams the returned colours out.
//
// Pixel stream: a pixel transfers on any cycle where pix_valid && pix_ready.
// While pix_valid is high and pix_ready is low, pix_color/pix_x/pix_y and the
// swept coordinate x/y are frozen, so no pixel is lost or duplicated.
module mode7_frame_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int ANGLE_MOD = 360
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [23:0] cfg_wdata,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] originx,
    output logic [15:0] originy,
    output logic [15:0] offsetx,
    output logic [15:0] offsety,
    output logic [23:0] scalex,
    output logic [23:0] scaley,
    output logic [15:0] angle,
    input  logic [7:0]  color,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_color,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [2:0] {S_IDLE, S_COMMIT, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
    localparam logic [16:0] AMOD   = 17'(ANGLE_MOD);
    localparam logic [23:0] ONE_FX = 24'h000100;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        pv_q, pv_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] px_q, px_d, py_q, py_d;
    logic        ovr_q, ovr_d;
    logic        dirty_q, dirty_d;

    logic [15:0] sh_originx_q, sh_originy_q, sh_offsetx_q, sh_offsety_q;
    logic [23:0] sh_scalex_q, sh_scaley_q;
    logic [15:0] sh_angle_q, sh_step_q;

    logic [15:0] act_originx_q, act_originy_q, act_offsetx_q, act_offsety_q;
    logic [23:0] act_scalex_q, act_scaley_q;
    logic [15:0] act_angle_q, angle_d;

    logic        angle_legal, angle_wr;
    logic [16:0] angle_sum;
    logic        advance;

    assign angle_legal = ({1'b0, cfg_wdata[15:0]} < AMOD);
    assign angle_wr    = cfg_we && (cfg_addr == 4'd6) && angle_legal;
    assign angle_sum   = {1'b0, act_angle_q} + {1'b0, sh_step_q};
    assign advance     = !pv_q || pix_ready;

    // Shadow registers: written by the config port in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_originx_q <= '0;
            sh_originy_q <= '0;
            sh_offsetx_q <= '0;
            sh_offsety_q <= '0;
            sh_scalex_q  <= ONE_FX;
            sh_scaley_q  <= ONE_FX;
            sh_angle_q   <= '0;
            sh_step_q    <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                4'd0: sh_originx_q <= cfg_wdata[15:0];
                4'd1: sh_originy_q <= cfg_wdata[15:0];
                4'd2: sh_offsetx_q <= cfg_wdata[15:0];
                4'd3: sh_offsety_q <= cfg_wdata[15:0];
                4'd4: sh_scalex_q  <= cfg_wdata;
                4'd5: sh_scaley_q  <= cfg_wdata;
                4'd6: if (angle_legal) sh_angle_q <= cfg_wdata[15:0];
                4'd7: if (angle_legal) sh_step_q  <= cfg_wdata[15:0];
                default: ;
            endcase
        end
    end

    // Active angle: fresh written angle wins, otherwise auto-rotate by step
    always_comb begin
        angle_d = act_angle_q;
        if (dirty_q)
            angle_d = sh_angle_q;
        else if (angle_sum >= AMOD)
            angle_d = 16'(angle_sum - AMOD);
        else
            angle_d = angle_sum[15:0];
    end

    // Active registers: loaded atomically only during COMMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_originx_q <= '0;
            act_originy_q <= '0;
            act_offsetx_q <= '0;
            act_offsety_q <= '0;
            act_scalex_q  <= ONE_FX;
            act_scaley_q  <= ONE_FX;
            act_angle_q   <= '0;
        end else if (state_q == S_COMMIT) begin
            act_originx_q <= sh_originx_q;
            act_originy_q <= sh_originy_q;
            act_offsetx_q <= sh_offsetx_q;
            act_offsety_q <= sh_offsety_q;
            act_scalex_q  <= sh_scalex_q;
            act_scaley_q  <= sh_scaley_q;
            act_angle_q   <= angle_d;
        end
    end

    // Next-state, sweep counters, output pixel register and flags
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pv_d    = pv_q;
        pc_d    = pc_q;
        px_d    = px_q;
        py_d    = py_q;
        ovr_d   = ovr_q || (start && (state_q != S_IDLE));
        // A write landing in the COMMIT cycle keeps dirty set for next frame
        dirty_d = angle_wr ? 1'b1 : ((state_q == S_COMMIT) ? 1'b0 : dirty_q);
        if (pv_q && pix_ready)
            pv_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (start) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                x_d     = '0;
                y_d     = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (advance) begin
                    pc_d = color;
                    px_d = x_q;
                    py_d = y_q;
                    pv_d = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = S_DRAIN;
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (pv_q && pix_ready) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, sweep and stream registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pv_q    <= 1'b0;
            pc_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            ovr_q   <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pv_q    <= pv_d;
            pc_q    <= pc_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ovr_q   <= ovr_d;
            dirty_q <= dirty_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign originx    = act_originx_q;
    assign originy    = act_originy_q;
    assign offsetx    = act_offsetx_q;
    assign offsety    = act_offsety_q;
    assign scalex     = act_scalex_q;
    assign scaley     = act_scaley_q;
    assign angle      = act_angle_q;
    assign pix_valid  = pv_q;
    assign pix_color  = pc_q;
    assign pix_x      = px_q;
    assign pix_y      = py_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_mode7_frame_ctrl.sv
// Bench for mode7_frame_ctrl on a reduced 8x4 frame.
module tb_mode7_frame_ctrl;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int N  = H * V;
  localparam int AM = 360;

  logic        clk = 1'b0;
  logic        reset, start, cfg_we, pix_ready;
  logic [3:0]  cfg_addr;
  logic [23:0] cfg_wdata;
  logic [7:0]  color;
  logic [15:0] x, y, originx, originy, offsetx, offsety, angle, pix_x, pix_y;
  logic [23:0] scalex, scaley;
  logic        pix_valid, busy, frame_done, overrun;
  logic [7:0]  pix_color;

  mode7_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ANGLE_MOD(AM)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .x(x), .y(y), .originx(originx), .originy(originy),
    .offsetx(offsetx), .offsety(offsety), .scalex(scalex), .scaley(scaley),
    .angle(angle), .color(color), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_color(pix_color), .pix_x(pix_x), .pix_y(pix_y), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in datapath: colour is a fixed function of the coordinate
  function automatic logic [7:0] colf(input logic [15:0] xx, input logic [15:0] yy);
    return 8'(32'(xx) * 37 + 32'(yy) * 11 + 5);
  endfunction
  assign color = colf(x, y);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // behavioural model: index 0..7 follows the config address map
  int  m_sh[8];
  int  m_act[8];
  bit  m_dirty;
  logic [39:0] exp_q[$];

  task automatic model_reset();
    m_sh    = '{0, 0, 0, 0, 256, 256, 0, 0};
    m_act   = '{0, 0, 0, 0, 256, 256, 0, 0};
    m_dirty = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_wr(input int a, input int d);
    if (a <= 3) m_sh[a] = d & 'hFFFF;
    else if (a <= 5) m_sh[a] = d & 'hFFFFFF;
    else if (a <= 7 && (d & 'hFFFF) < AM) begin
      m_sh[a] = d & 'hFFFF;
      if (a == 6) m_dirty = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
    if (m_dirty) begin
      m_act[6] = m_sh[6];
      m_dirty  = 1'b0;
    end else begin
      m_act[6] = (m_act[6] + m_sh[7]) % AM;
    end
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        exp_q.push_back({16'(xx), 16'(yy), colf(16'(xx), 16'(yy))});
  endtask

  // scoreboard / compare process
  bit          chk_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [39:0] prev_pix;
  logic [31:0] prev_xy;
  int          hs_cnt = 0;
  int          last_hs = -1;

  always @(negedge clk) begin
    if (reset || !chk_en) begin
      prev_stall = 1'b0;
    end else begin
      check("originx", 64'(originx), 64'(m_act[0]));
      check("originy", 64'(originy), 64'(m_act[1]));
      check("offsetx", 64'(offsetx), 64'(m_act[2]));
      check("offsety", 64'(offsety), 64'(m_act[3]));
      check("scalex", 64'(scalex), 64'(m_act[4]));
      check("scaley", 64'(scaley), 64'(m_act[5]));
      check("angle", 64'(angle), 64'(m_act[6]));
      if (!busy) check("idle_xy", 64'({x, y}), 64'(0));
      if (prev_stall) begin
        check("stall_valid", 64'(pix_valid), 64'(1));
        check("stall_pix", 64'({pix_x, pix_y, pix_color}), 64'(prev_pix));
        check("stall_xy", 64'({x, y}), 64'(prev_xy));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) fail_now("extra_pixel");
        else check("pixel", 64'({pix_x, pix_y, pix_color}), 64'(exp_q.pop_front()));
        hs_cnt++;
        last_hs = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = {pix_x, pix_y, pix_color};
      prev_xy    = {x, y};
    end
  end

  // driver tasks
  task automatic cfg_write(input int a, input int d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_wdata = 24'(d);
    model_wr(a, d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // mode: 0 plain, 1 backpressure at (H-1,0), 2 start mid-run,
  //       3 scalex write mid-run, 4 reset mid-frame
  task automatic run_frame(input int mode);
    int t0, first_v, done_at, hs0, stall;
    bit flag;
    first_v = -1; done_at = -1; stall = 0; flag = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; pix_ready = 1'b1; t0 = cyc; hs0 = hs_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    model_commit();
    for (int c = 0; c < 4 * N + 50; c++) begin
      @(negedge clk);
      if (pix_valid && first_v < 0) first_v = cyc;
      if (frame_done) begin
        done_at = cyc;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      if (stall > 0) begin
        pix_ready = 1'b0;
        stall--;
      end else begin
        pix_ready = 1'b1;
        if (!flag && pix_valid) begin
          if (mode == 1 && pix_x == 16'(H - 1) && pix_y == 16'd0) begin
            pix_ready = 1'b0; stall = 4; flag = 1'b1;
          end
          if (mode == 2 && pix_x == 16'd3 && pix_y == 16'd1) begin
            start = 1'b1; flag = 1'b1;
          end
          if (mode == 3 && pix_x == 16'd2 && pix_y == 16'd2) begin
            cfg_we = 1'b1; cfg_addr = 4'd4; cfg_wdata = 24'h000300;
            model_wr(4, 'h300); flag = 1'b1;
          end
          if (mode == 4 && pix_x == 16'd4 && pix_y == 16'd2) begin
            #1 reset = 1'b1;
            #1;
            check("rst_pix_valid", 64'(pix_valid), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_xy", 64'({x, y}), 64'(0));
            check("rst_overrun", 64'(overrun), 64'(0));
            check("rst_scalex", 64'(scalex), 64'(24'h000100));
            model_reset();
            @(posedge clk); #1;
            reset = 1'b0;
            return;
          end
        end
      end
    end
    pix_ready = 1'b1;
    if (done_at < 0) begin
      fail_now("frame_timeout");
      return;
    end
    check("first_valid_cycle", 64'(first_v), 64'(t0 + 3));
    check("frame_done_cycle", 64'(done_at), 64'(t0 + N + 3 + ((mode == 1) ? 5 : 0)));
    check("handshakes", 64'(hs_cnt - hs0), 64'(N));
    check("last_hs_cycle", 64'(last_hs), 64'(done_at - 1));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("done_pulse_len", 64'(frame_done), 64'(0));
    check("busy_after", 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    pix_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_xy", 64'({x, y}), 64'(0));
    check("reset_pix", 64'({pix_valid, pix_color, pix_x, pix_y}), 64'(0));
    check("reset_flags", 64'({busy, frame_done, overrun}), 64'(0));
    check("reset_origin", 64'({originx, originy, offsetx, offsety}), 64'(0));
    check("reset_angle", 64'(angle), 64'(0));
    check("reset_scalex", 64'(scalex), 64'(24'h000100));
    check("reset_scaley", 64'(scaley), 64'(24'h000100));
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    // full frame with parameters and angle 90
    cfg_write(0, 'h1234); cfg_write(1, 'hBEEF); cfg_write(2, 7);
    cfg_write(3, 'hFFFF); cfg_write(4, 'h012345); cfg_write(5, 'h800000);
    cfg_write(6, 90);
    run_frame(0);
    check("angle_f1", 64'(angle), 64'(90));
    check("originy_f1", 64'(originy), 64'(16'hBEEF));

    // backpressure at end of first line
    run_frame(1);
    check("angle_bp", 64'(angle), 64'(90));

    // auto-rotate 20 -> 10 -> 0
    cfg_write(6, 20); cfg_write(7, 350);
    run_frame(0); check("rot_f1", 64'(angle), 64'(20));
    run_frame(0); check("rot_f2", 64'(angle), 64'(10));
    run_frame(0); check("rot_f3", 64'(angle), 64'(0));

    // start while running
    check("overrun_before", 64'(overrun), 64'(0));
    run_frame(2);
    check("overrun_after", 64'(overrun), 64'(1));
    check("angle_after_ovr", 64'(angle), 64'(350));

    // illegal angle and step writes are dropped: 350 + 350 wraps to 340
    cfg_write(6, 400); cfg_write(7, 500);
    run_frame(0);
    check("angle_illegal", 64'(angle), 64'(340));

    // scalex written mid-frame only lands at the next commit
    check("scalex_pre", 64'(scalex), 64'(24'h012345));
    run_frame(3);
    check("scalex_same", 64'(scalex), 64'(24'h012345));
    run_frame(0);
    check("scalex_new", 64'(scalex), 64'(24'h000300));

    // reset mid-frame, then a clean frame from defaults
    run_frame(4);
    run_frame(0);
    check("post_rst_angle", 64'(angle), 64'(0));
    check("post_rst_scalex", 64'(scalex), 64'(24'h000100));
    check("post_rst_overrun", 64'(overrun), 64'(0));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
